// File: rtl/riscv_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | riscv_pkg : shared RISC-V core types for the hazard/stall controller   |
// | Revision  : 1.0                                                         |
// +------------------------------------------------------------------------+
package riscv_pkg;

    // Slot dr is sized for the widest legal register address; narrower REG_AW zero-extends.
    localparam int                      C_REG_AW_MAX = 8;
    localparam logic [C_REG_AW_MAX-1:0] C_REG_X0     = '0;

    typedef struct packed {
        logic                    v;
        logic [C_REG_AW_MAX-1:0] dr;
        logic                    wen;
        logic                    ld;
        logic                    br;
    } hz_slot_t;

endpackage
`default_nettype wire

// File: rtl/hz_match.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | hz_match : one in-flight slot versus one decode source register        |
// | Revision : 1.0                                                          |
// +------------------------------------------------------------------------+
module hz_match
    import riscv_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  hz_slot_t          i_slot,
    input  logic [REG_AW-1:0] i_rs,
    input  logic              i_use,
    output logic              o_match
);

    logic w_writer;
    logic w_unused_flags;

    // A non-zero dr equal to rs also rules out x0 on the source side.
    assign w_writer       = i_slot.v & i_slot.wen & (i_slot.dr != C_REG_X0);
    assign o_match        = w_writer & i_use & (i_slot.dr == C_REG_AW_MAX'(i_rs));
    assign w_unused_flags = i_slot.ld ^ i_slot.br;

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | pipe_hazard_ctrl : decode RAW stall, fetch branch stall, issue valid   |
// | Revision         : 1.0                                                  |
// +------------------------------------------------------------------------+
module pipe_hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int NUM_STAGES   = 3,
    parameter int REG_AW       = 5,
    parameter bit FWD_EN       = 1'b0,
    parameter bit RF_WR_BYPASS = 1'b1,
    parameter int CNT_W        = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              DE_V,
    input  logic [REG_AW-1:0] DE_RS1,
    input  logic [REG_AW-1:0] DE_RS2,
    input  logic              DE_RS1_USE,
    input  logic              DE_RS2_USE,
    input  logic [REG_AW-1:0] DE_DR,
    input  logic              DE_WEN,
    input  logic              DE_IS_LD,
    input  logic              DE_IS_BR,
    input  logic              HOLD,
    output logic              DE_STALL,
    output logic              FE_STALL,
    output logic              FE_BR_STALL,
    output logic              EXE_V,
    output logic [CNT_W-1:0]  STALL_CNT
);

    hz_slot_t              r_slot_q [NUM_STAGES];
    hz_slot_t              w_slot_d [NUM_STAGES];
    hz_slot_t              w_de_slot;
    logic [NUM_STAGES-1:0] w_hit_rs1;
    logic [NUM_STAGES-1:0] w_hit_rs2;
    logic [NUM_STAGES-1:0] w_in_set;
    logic [NUM_STAGES-1:0] w_slot_br;
    logic                  w_raw;
    logic                  w_de_stall;
    logic                  w_issue;
    logic [CNT_W-1:0]      r_stall_cnt_q;
    logic [CNT_W-1:0]      w_stall_cnt_d;

    assign w_raw      = DE_V & (|((w_hit_rs1 | w_hit_rs2) & w_in_set));
    assign w_de_stall = w_raw | HOLD;
    assign w_issue    = DE_V & ~w_de_stall;

    // A stalled decode enters execute as a bubble.
    assign w_de_slot = '{v: w_issue, dr: C_REG_AW_MAX'(DE_DR), wen: DE_WEN,
                         ld: DE_IS_LD, br: DE_IS_BR};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_STAGES; gi++) begin : g_slot
            hz_match #(.REG_AW(REG_AW)) u_match_rs1 (
                .i_slot  (r_slot_q[gi]),
                .i_rs    (DE_RS1),
                .i_use   (DE_RS1_USE),
                .o_match (w_hit_rs1[gi])
            );
            hz_match #(.REG_AW(REG_AW)) u_match_rs2 (
                .i_slot  (r_slot_q[gi]),
                .i_rs    (DE_RS2),
                .i_use   (DE_RS2_USE),
                .o_match (w_hit_rs2[gi])
            );

            if (FWD_EN) begin : g_fwd
                if (gi == 0) begin : g_load_use
                    assign w_in_set[gi] = r_slot_q[gi].ld;
                end else begin : g_forwarded
                    assign w_in_set[gi] = 1'b0;
                end
            end else if (RF_WR_BYPASS && (gi == NUM_STAGES - 1)) begin : g_bypassed
                assign w_in_set[gi] = 1'b0;
            end else begin : g_pending
                assign w_in_set[gi] = 1'b1;
            end

            assign w_slot_br[gi] = r_slot_q[gi].v & r_slot_q[gi].br;

            if (gi == 0) begin : g_head
                assign w_slot_d[gi] = HOLD ? r_slot_q[gi] : w_de_slot;
            end else begin : g_tail
                assign w_slot_d[gi] = HOLD ? r_slot_q[gi] : r_slot_q[gi-1];
            end
        end
    endgenerate

    always_comb begin
        w_stall_cnt_d = r_stall_cnt_q;
        if (w_de_stall && (r_stall_cnt_q != {CNT_W{1'b1}})) begin
            w_stall_cnt_d = r_stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_slot_q      <= '{default: '0};
            r_stall_cnt_q <= '0;
        end else begin
            r_slot_q      <= w_slot_d;
            r_stall_cnt_q <= w_stall_cnt_d;
        end
    end

    assign DE_STALL    = w_de_stall;
    assign FE_STALL    = w_de_stall;
    assign FE_BR_STALL = (DE_V & DE_IS_BR) | (|w_slot_br);
    assign EXE_V       = r_slot_q[0].v;
    assign STALL_CNT   = r_stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_pipe_hazard_ctrl : three configurations against a behavioural model |
// | Revision            : 1.0                                               |
// +------------------------------------------------------------------------+
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst, hold, de_v, de_rs1_use, de_rs2_use, de_wen, de_is_ld, de_is_br;
    logic [4:0] de_rs1, de_rs2, de_dr;
    logic [2:0] de_stall, fe_stall, fe_br, exe_v;
    logic [31:0] cnt_a, cnt_b;
    logic [1:0]  cnt_c;
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // a: 3 stages, no forwarding, RF bypass; b: load-use only; c: 4 stages, no bypass, 2-bit counter
    pipe_hazard_ctrl #(.NUM_STAGES(3), .REG_AW(5), .FWD_EN(1'b0), .RF_WR_BYPASS(1'b1), .CNT_W(32)) dut_a (
        .CLK(clk), .RESET(rst), .DE_V(de_v), .DE_RS1(de_rs1), .DE_RS2(de_rs2),
        .DE_RS1_USE(de_rs1_use), .DE_RS2_USE(de_rs2_use), .DE_DR(de_dr), .DE_WEN(de_wen),
        .DE_IS_LD(de_is_ld), .DE_IS_BR(de_is_br), .HOLD(hold), .DE_STALL(de_stall[0]),
        .FE_STALL(fe_stall[0]), .FE_BR_STALL(fe_br[0]), .EXE_V(exe_v[0]), .STALL_CNT(cnt_a));
    pipe_hazard_ctrl #(.NUM_STAGES(3), .REG_AW(5), .FWD_EN(1'b1), .RF_WR_BYPASS(1'b1), .CNT_W(32)) dut_b (
        .CLK(clk), .RESET(rst), .DE_V(de_v), .DE_RS1(de_rs1), .DE_RS2(de_rs2),
        .DE_RS1_USE(de_rs1_use), .DE_RS2_USE(de_rs2_use), .DE_DR(de_dr), .DE_WEN(de_wen),
        .DE_IS_LD(de_is_ld), .DE_IS_BR(de_is_br), .HOLD(hold), .DE_STALL(de_stall[1]),
        .FE_STALL(fe_stall[1]), .FE_BR_STALL(fe_br[1]), .EXE_V(exe_v[1]), .STALL_CNT(cnt_b));
    pipe_hazard_ctrl #(.NUM_STAGES(4), .REG_AW(5), .FWD_EN(1'b0), .RF_WR_BYPASS(1'b0), .CNT_W(2)) dut_c (
        .CLK(clk), .RESET(rst), .DE_V(de_v), .DE_RS1(de_rs1), .DE_RS2(de_rs2),
        .DE_RS1_USE(de_rs1_use), .DE_RS2_USE(de_rs2_use), .DE_DR(de_dr), .DE_WEN(de_wen),
        .DE_IS_LD(de_is_ld), .DE_IS_BR(de_is_br), .HOLD(hold), .DE_STALL(de_stall[2]),
        .FE_STALL(fe_stall[2]), .FE_BR_STALL(fe_br[2]), .EXE_V(exe_v[2]), .STALL_CNT(cnt_c));

    // Reference model: each configuration is a list of in-flight instructions.
    typedef struct {
        bit v;
        int dr;
        bit wen;
        bit ld;
        bit br;
    } m_slot_t;

    m_slot_t m_slot [3][8];
    longint  m_cnt  [3];
    int      p_ns   [3] = '{3, 3, 4};
    bit      p_fwd  [3] = '{1'b0, 1'b1, 1'b0};
    bit      p_byp  [3] = '{1'b1, 1'b1, 1'b0};
    longint  p_cmax [3] = '{64'd4294967295, 64'd4294967295, 64'd3};

    function automatic bit m_in_set(int k, int s);
        if (p_fwd[k]) return (s == 0) && m_slot[k][s].ld;
        return !(p_byp[k] && (s == p_ns[k] - 1));
    endfunction

    function automatic bit m_raw(int k);
        bit r = 1'b0;
        if (!de_v) return 1'b0;
        for (int s = 0; s < p_ns[k]; s++) begin
            if (m_slot[k][s].v && m_slot[k][s].wen && m_slot[k][s].dr != 0 && m_in_set(k, s)) begin
                if (de_rs1_use && int'(de_rs1) == m_slot[k][s].dr) r = 1'b1;
                if (de_rs2_use && int'(de_rs2) == m_slot[k][s].dr) r = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic bit m_br(int k);
        bit r = de_v && de_is_br;
        for (int s = 0; s < p_ns[k]; s++) if (m_slot[k][s].v && m_slot[k][s].br) r = 1'b1;
        return r;
    endfunction

    function automatic void m_clock(int k);
        bit st;
        st = m_raw(k) | hold;
        if (rst) begin
            for (int s = 0; s < 8; s++) m_slot[k][s] = '{v: 1'b0, dr: 0, wen: 1'b0, ld: 1'b0, br: 1'b0};
            m_cnt[k] = 0;
            return;
        end
        if (st && m_cnt[k] < p_cmax[k]) m_cnt[k] = m_cnt[k] + 1;
        if (!hold) begin
            for (int s = p_ns[k] - 1; s > 0; s--) m_slot[k][s] = m_slot[k][s-1];
            m_slot[k][0] = '{v: de_v && !st, dr: int'(de_dr), wen: de_wen, ld: de_is_ld, br: de_is_br};
        end
    endfunction

    function automatic longint dut_cnt(int k);
        case (k)
            0:       return longint'(cnt_a);
            1:       return longint'(cnt_b);
            default: return longint'(cnt_c);
        endcase
    endfunction

    task automatic cycle();
        @(posedge clk);
        for (int k = 0; k < 3; k++) m_clock(k);
        #1;
    endtask

    task automatic clr_in();
        rst = 1'b0; hold = 1'b0; de_v = 1'b0;
        de_rs1 = '0; de_rs2 = '0; de_rs1_use = 1'b0; de_rs2_use = 1'b0;
        de_dr = '0; de_wen = 1'b0; de_is_ld = 1'b0; de_is_br = 1'b0;
    endtask

    task automatic do_reset();
        clr_in();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #2;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (exe_v[k] !== 1'b0) begin n_fail++; $display("FAIL reset_exe_v dut%0d: got %b want 0", k, exe_v[k]); end
            n_checks++;
            if (de_stall[k] !== 1'b0) begin n_fail++; $display("FAIL reset_de_stall dut%0d: got %b want 0", k, de_stall[k]); end
            n_checks++;
            if (dut_cnt(k) !== 64'd0) begin n_fail++; $display("FAIL reset_cnt dut%0d: got %0d want 0", k, dut_cnt(k)); end
        end
        de_v = 1'b1; de_dr = 5'd5; de_wen = 1'b1;
        cycle();
        clr_in();
        #2;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (exe_v[k] !== 1'b1) begin n_fail++; $display("FAIL first_issue_exe_v dut%0d: got %b want 1", k, exe_v[k]); end
        end
    endtask

    task automatic test_raw_no_fwd();
        int n = 0;
        do_reset();
        de_v = 1'b1; de_dr = 5'd5; de_wen = 1'b1;
        cycle();
        de_wen = 1'b0; de_dr = '0; de_rs1 = 5'd5; de_rs1_use = 1'b1; de_is_br = 1'b1;
        #2;
        n_checks++;
        if (de_stall[0] !== 1'b1 || fe_br[0] !== 1'b1)
            begin n_fail++; $display("FAIL raw_with_branch: got stall=%b br=%b want 1/1", de_stall[0], fe_br[0]); end
        n_checks++;
        if (fe_stall[0] !== de_stall[0]) begin n_fail++; $display("FAIL fe_stall_follow: got %b want %b", fe_stall[0], de_stall[0]); end
        for (int i = 0; i < 10; i++) begin
            if (i > 0) #2;
            if (!de_stall[0]) break;
            n++;
            cycle();
        end
        n_checks++;
        if (n != 2) begin n_fail++; $display("FAIL raw_stall_cycles: got %0d want 2", n); end
        cycle();
        clr_in();
        #2;
        n_checks++;
        if (exe_v[0] !== 1'b1) begin n_fail++; $display("FAIL raw_then_issue: got %b want 1", exe_v[0]); end
        n_checks++;
        if (cnt_a !== 32'd2) begin n_fail++; $display("FAIL raw_stall_cnt: got %0d want 2", cnt_a); end
    endtask

    task automatic test_load_use();
        int n = 0;
        do_reset();
        de_v = 1'b1; de_dr = 5'd7; de_wen = 1'b1; de_is_ld = 1'b1;
        cycle();
        de_dr = '0; de_wen = 1'b0; de_is_ld = 1'b0; de_rs2 = 5'd7; de_rs2_use = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #2;
            if (!de_stall[1]) break;
            n++;
            cycle();
        end
        n_checks++;
        if (n != 1) begin n_fail++; $display("FAIL load_use_cycles: got %0d want 1", n); end
        do_reset();
        de_v = 1'b1; de_dr = 5'd7; de_wen = 1'b1;
        cycle();
        de_dr = '0; de_wen = 1'b0; de_rs2 = 5'd7; de_rs2_use = 1'b1;
        #2;
        n_checks++;
        if (de_stall[1] !== 1'b0) begin n_fail++; $display("FAIL fwd_alu_no_stall: got %b want 0", de_stall[1]); end
        n_checks++;
        if (de_stall[0] !== 1'b1) begin n_fail++; $display("FAIL nofwd_alu_stall: got %b want 1", de_stall[0]); end
    endtask

    task automatic test_x0_unused();
        do_reset();
        de_v = 1'b1; de_dr = 5'd0; de_wen = 1'b1;
        cycle();
        de_wen = 1'b0; de_rs1 = 5'd0; de_rs1_use = 1'b1;
        #2;
        n_checks++;
        if (de_stall[0] !== 1'b0) begin n_fail++; $display("FAIL x0_no_stall: got %b want 0", de_stall[0]); end
        clr_in();
        de_v = 1'b1; de_dr = 5'd9; de_wen = 1'b1;
        cycle();
        de_wen = 1'b0; de_dr = '0; de_rs1 = 5'd9; de_rs1_use = 1'b0; de_rs2 = 5'd3; de_rs2_use = 1'b1;
        #2;
        n_checks++;
        if (de_stall[0] !== 1'b0) begin n_fail++; $display("FAIL unused_rs1_no_stall: got %b want 0", de_stall[0]); end
        de_rs2 = 5'd9;
        #2;
        n_checks++;
        if (de_stall[0] !== 1'b1) begin n_fail++; $display("FAIL rs2_match_stall: got %b want 1", de_stall[0]); end
        de_v = 1'b0;
        #2;
        n_checks++;
        if (de_stall[0] !== 1'b0) begin n_fail++; $display("FAIL invalid_decode_no_stall: got %b want 0", de_stall[0]); end
        clr_in();
    endtask

    task automatic test_branch_lifetime();
        int n = 0;
        do_reset();
        de_v = 1'b1; de_is_br = 1'b1;
        #2;
        n_checks++;
        if (fe_br[2] !== 1'b1) begin n_fail++; $display("FAIL br_decode_cycle: got %b want 1", fe_br[2]); end
        cycle();
        clr_in();
        for (int i = 0; i < 20; i++) begin
            #2;
            if (!fe_br[2]) break;
            n++;
            cycle();
        end
        n_checks++;
        if (n != 4) begin n_fail++; $display("FAIL br_lifetime: got %0d want 4", n); end
        de_v = 1'b1; de_is_br = 1'b1;
        cycle();
        clr_in();
        n = 0;
        for (int i = 0; i < 20; i++) begin
            hold = (i < 3);
            #2;
            if (!fe_br[2]) break;
            n++;
            cycle();
        end
        hold = 1'b0;
        n_checks++;
        if (n != 7) begin n_fail++; $display("FAIL br_lifetime_hold: got %0d want 7", n); end
    endtask

    task automatic test_hold_reset_sat();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            de_v = 1'b1; de_wen = 1'b1; de_dr = 5'(10 + i);
            cycle();
        end
        clr_in();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            n_checks++;
            if (de_stall[0] !== 1'b1 || fe_stall[0] !== 1'b1)
                begin n_fail++; $display("FAIL hold_stall: got %b/%b want 1/1", de_stall[0], fe_stall[0]); end
            cycle();
            n_checks++;
            if (cnt_a !== 32'(i + 1)) begin n_fail++; $display("FAIL hold_cnt: got %0d want %0d", cnt_a, i + 1); end
            n_checks++;
            if (exe_v[0] !== 1'b1) begin n_fail++; $display("FAIL hold_exe_v: got %b want 1", exe_v[0]); end
        end
        hold = 1'b0; de_v = 1'b1; de_rs1 = 5'd12; de_rs1_use = 1'b1;
        #2;
        n_checks++;
        if (de_stall[0] !== 1'b1 || de_stall[2] !== 1'b1)
            begin n_fail++; $display("FAIL hold_frozen: got a=%b c=%b want 1/1", de_stall[0], de_stall[2]); end
        clr_in();
        rst = 1'b1; hold = 1'b1;
        cycle();
        rst = 1'b0; hold = 1'b0;
        #2;
        n_checks++;
        if (exe_v !== 3'b000) begin n_fail++; $display("FAIL reset_in_hold_exe_v: got %b want 000", exe_v); end
        n_checks++;
        if (cnt_a !== 32'd0 || cnt_c !== 2'd0) begin n_fail++; $display("FAIL reset_in_hold_cnt: got %0d/%0d want 0/0", cnt_a, cnt_c); end
        de_v = 1'b1; de_rs1 = 5'd13; de_rs1_use = 1'b1;
        #2;
        n_checks++;
        if (de_stall !== 3'b000) begin n_fail++; $display("FAIL reset_in_hold_empty: got %b want 000", de_stall); end
        clr_in();
        hold = 1'b1;
        repeat (5) cycle();
        hold = 1'b0;
        #2;
        n_checks++;
        if (cnt_c !== 2'd3) begin n_fail++; $display("FAIL cnt_saturate: got %0d want 3", cnt_c); end
        n_checks++;
        if (cnt_a !== 32'd5) begin n_fail++; $display("FAIL cnt_wide_five: got %0d want 5", cnt_a); end
    endtask

    task automatic test_random();
        bit exp_st;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rst        = ($urandom_range(0, 59) == 0);
            hold       = ($urandom_range(0, 4) == 0);
            de_v       = ($urandom_range(0, 3) != 0);
            de_rs1     = 5'($urandom_range(0, 6));
            de_rs2     = 5'($urandom_range(0, 6));
            de_rs1_use = 1'($urandom_range(0, 1));
            de_rs2_use = 1'($urandom_range(0, 1));
            de_dr      = 5'($urandom_range(0, 6));
            de_wen     = ($urandom_range(0, 3) != 0);
            de_is_ld   = 1'($urandom_range(0, 1));
            de_is_br   = ($urandom_range(0, 5) == 0);
            #2;
            for (int k = 0; k < 3; k++) begin
                exp_st = m_raw(k) | hold;
                n_checks++;
                if (de_stall[k] !== exp_st) begin n_fail++; $display("FAIL rand_de_stall dut%0d cyc%0d: got %b want %b", k, c, de_stall[k], exp_st); end
                n_checks++;
                if (fe_stall[k] !== exp_st) begin n_fail++; $display("FAIL rand_fe_stall dut%0d cyc%0d: got %b want %b", k, c, fe_stall[k], exp_st); end
                n_checks++;
                if (fe_br[k] !== m_br(k)) begin n_fail++; $display("FAIL rand_fe_br dut%0d cyc%0d: got %b want %b", k, c, fe_br[k], m_br(k)); end
                n_checks++;
                if (exe_v[k] !== m_slot[k][0].v) begin n_fail++; $display("FAIL rand_exe_v dut%0d cyc%0d: got %b want %b", k, c, exe_v[k], m_slot[k][0].v); end
                n_checks++;
                if (dut_cnt(k) !== m_cnt[k]) begin n_fail++; $display("FAIL rand_cnt dut%0d cyc%0d: got %0d want %0d", k, c, dut_cnt(k), m_cnt[k]); end
            end
            cycle();
        end
        clr_in();
    endtask

    initial begin
        clr_in();
        rst = 1'b1;
        test_reset();
        test_raw_no_fwd();
        test_load_use();
        test_x0_unused();
        test_branch_lifetime();
        test_hold_reset_sat();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
